// File: rtl/conv2_pkg.sv
// Shared constants and state encoding for the conv2 layer scheduler.
package conv2_pkg;

    localparam int WIDTH       = 12;
    localparam int HEIGHT      = 12;
    localparam int FILTER_SIZE = 5;
    localparam int DATA_BITS   = 12;
    localparam int CH_BITS     = 2;
    localparam int ADDR_BITS   = 10;
    localparam int FLUSH_MAX   = 64;

    localparam int OUT_W   = WIDTH - FILTER_SIZE + 1;
    localparam int OUT_H   = HEIGHT - FILTER_SIZE + 1;
    localparam int NUM_WIN = OUT_W * OUT_H;
    localparam int NUM_PIX = WIDTH * HEIGHT;

    localparam int PIX_BITS   = $clog2(NUM_PIX);
    localparam int WIN_BITS   = $clog2(NUM_WIN + 1);
    localparam int IDX_BITS   = $clog2(NUM_WIN);
    localparam int FLUSH_BITS = $clog2(FLUSH_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_NEXT   = 3'd4,
        S_FIN    = 3'd5
    } state_t;

endpackage

// File: rtl/conv2_addr_gen.sv
// Channel/pixel address generation for the pool1 feature-map RAM, plus the
// one-cycle read-latency alignment that feeds the line buffer.
module conv2_addr_gen
    import conv2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_first_ch,
    input  logic                 i_next_ch,
    input  logic                 i_clr,
    input  logic                 i_rd,
    input  logic                 i_flush,
    input  logic [DATA_BITS-1:0] i_rd_data,
    output logic                 o_rd_en,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic                 o_last_pix,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data,
    output logic [CH_BITS-1:0]   o_ch
);

    logic [PIX_BITS-1:0]  r_pix;
    logic [ADDR_BITS-1:0] r_base;
    logic [CH_BITS-1:0]   r_ch;
    logic                 r_rd_vld;
    logic                 w_last_pix;

    assign w_last_pix = (r_pix == PIX_BITS'(NUM_PIX - 1));

    // The pixel counter parks on the last pixel so the address never runs past the channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix    <= '0;
            r_base   <= '0;
            r_ch     <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= i_rd;
            if (i_first_ch) begin
                r_base <= '0;
                r_ch   <= '0;
            end else if (i_next_ch) begin
                r_base <= r_base + ADDR_BITS'(NUM_PIX);
                r_ch   <= r_ch + 1'b1;
            end
            if (i_clr) begin
                r_pix <= '0;
            end else if (i_rd && !w_last_pix) begin
                r_pix <= r_pix + 1'b1;
            end
        end
    end

    assign o_rd_en    = i_rd;
    assign o_addr     = r_base + ADDR_BITS'(r_pix);
    assign o_last_pix = w_last_pix;
    assign o_valid    = r_rd_vld | i_flush;
    assign o_data     = r_rd_vld ? i_rd_data : '0;
    assign o_ch       = r_ch;

endmodule

// File: rtl/conv2_sched.sv
// conv2 layer scheduler: walks every input channel through the 5x5 line buffer
// and tags each emerging window for the multiply-accumulate bank.
module conv2_sched
    import conv2_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CH_BITS-1:0]   cfg_num_ch,
    output logic                 busy,
    output logic                 done,
    output logic                 err_timeout,
    output logic                 fm_rd_en,
    output logic [ADDR_BITS-1:0] fm_addr,
    input  logic [DATA_BITS-1:0] fm_rd_data,
    output logic                 buf_rst_n,
    output logic                 buf_valid_in,
    output logic [DATA_BITS-1:0] buf_data_in,
    input  logic                 buf_valid_out,
    output logic                 acc_en,
    output logic                 acc_first,
    output logic                 acc_last,
    output logic [IDX_BITS-1:0]  win_idx,
    output logic [CH_BITS-1:0]   ch_idx
);

    state_t                r_state;
    state_t                w_next;
    logic [CH_BITS-1:0]    r_last_ch;
    logic                  r_err;
    logic                  r_buf_rst_n;
    logic [WIN_BITS-1:0]   r_win;
    logic [WIN_BITS-1:0]   w_win_next;
    logic [FLUSH_BITS-1:0] r_flush;
    logic                  w_first_ch;
    logic                  w_next_ch;
    logic                  w_timeout;
    logic                  w_count_win;
    logic                  w_acc_en;
    logic                  w_last_pix;
    logic [CH_BITS-1:0]    w_ch;

    conv2_addr_gen u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_first_ch (w_first_ch),
        .i_next_ch  (w_next_ch),
        .i_clr      (r_state == S_CLR),
        .i_rd       (r_state == S_STREAM),
        .i_flush    (r_state == S_FLUSH),
        .i_rd_data  (fm_rd_data),
        .o_rd_en    (fm_rd_en),
        .o_addr     (fm_addr),
        .o_last_pix (w_last_pix),
        .o_valid    (buf_valid_in),
        .o_data     (buf_data_in),
        .o_ch       (w_ch)
    );

    assign w_count_win = (r_state == S_CLR) || (r_state == S_STREAM) || (r_state == S_FLUSH);
    assign w_acc_en    = w_count_win && buf_valid_out && (r_win < WIN_BITS'(NUM_WIN));
    assign w_win_next  = r_win + WIN_BITS'(w_acc_en);

    always_comb begin
        w_next     = r_state;
        w_first_ch = 1'b0;
        w_next_ch  = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next     = S_CLR;
                    w_first_ch = 1'b1;
                end
            end
            S_CLR:    w_next = S_STREAM;
            S_STREAM: if (w_last_pix) w_next = S_FLUSH;
            S_FLUSH: begin
                // A window landing on the final flush cycle still completes the channel cleanly.
                if (w_win_next == WIN_BITS'(NUM_WIN)) begin
                    w_next = S_NEXT;
                end else if (r_flush == FLUSH_BITS'(FLUSH_MAX - 1)) begin
                    w_next    = S_NEXT;
                    w_timeout = 1'b1;
                end
            end
            S_NEXT: begin
                if (w_ch == r_last_ch) begin
                    w_next = S_FIN;
                end else begin
                    w_next    = S_CLR;
                    w_next_ch = 1'b1;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_ch   <= '0;
            r_err       <= 1'b0;
            r_buf_rst_n <= 1'b0;
            r_win       <= '0;
            r_flush     <= '0;
        end else begin
            r_state     <= w_next;
            r_buf_rst_n <= (w_next != S_CLR);
            if (w_first_ch) begin
                r_last_ch <= (cfg_num_ch == '0) ? '0 : cfg_num_ch - 1'b1;
                r_err     <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
            // Counters are zeroed on the way into CLR so windows during CLR are indexed from 0.
            if (w_next == S_CLR) begin
                r_win   <= '0;
                r_flush <= '0;
            end else begin
                r_win <= w_win_next;
                if (r_state == S_FLUSH && w_next == S_FLUSH) begin
                    r_flush <= r_flush + 1'b1;
                end
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_FIN);
    assign err_timeout = r_err;
    assign buf_rst_n   = r_buf_rst_n;
    assign acc_en      = w_acc_en;
    assign acc_first   = w_acc_en && (w_ch == '0);
    assign acc_last    = w_acc_en && (w_ch == r_last_ch);
    assign win_idx     = r_win[IDX_BITS-1:0];
    assign ch_idx      = w_ch;

endmodule

// File: tb/tb_conv2_sched.sv
// Randomized bench for conv2_sched with a RAM model, a line-buffer model and a
// transaction-level reference of reads, windows and flush lengths.
module tb_conv2_sched;
    import conv2_pkg::*;

    localparam int M_NORMAL = 0;
    localparam int M_EXCESS = 1;
    localparam int M_NONE   = 2;

    typedef struct {
        int idx;
        int first;
        int last;
        int ch;
    } win_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [CH_BITS-1:0]   cfg_num_ch;
    logic                 busy, done, err_timeout, fm_rd_en;
    logic [ADDR_BITS-1:0] fm_addr;
    logic [DATA_BITS-1:0] fm_rd_data;
    logic                 buf_rst_n, buf_valid_in;
    logic [DATA_BITS-1:0] buf_data_in;
    logic                 buf_valid_out;
    logic                 acc_en, acc_first, acc_last;
    logic [IDX_BITS-1:0]  win_idx;
    logic [CH_BITS-1:0]   ch_idx;

    always #5 clk = ~clk;

    conv2_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_num_ch    (cfg_num_ch),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .fm_rd_en      (fm_rd_en),
        .fm_addr       (fm_addr),
        .fm_rd_data    (fm_rd_data),
        .buf_rst_n     (buf_rst_n),
        .buf_valid_in  (buf_valid_in),
        .buf_data_in   (buf_data_in),
        .buf_valid_out (buf_valid_out),
        .acc_en        (acc_en),
        .acc_first     (acc_first),
        .acc_last      (acc_last),
        .win_idx       (win_idx),
        .ch_idx        (ch_idx)
    );

    int total = 0;
    int bad   = 0;

    function automatic void check(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endfunction

    // Buffer model: emits a window one cycle after the pixel that completes it.
    function automatic bit pulse_at(int mode, int p);
        if (mode == M_NONE || p < 0) return 1'b0;
        if (p < NUM_PIX && (p / WIDTH) >= FILTER_SIZE - 1 && (p % WIDTH) >= FILTER_SIZE - 1) return 1'b1;
        if (mode == M_EXCESS && p < 6) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pulse_total(int mode);
        int cnt = 0;
        for (int p = 0; p < 400; p++) if (pulse_at(mode, p)) cnt++;
        return cnt;
    endfunction

    // Zero-filled flush cycles per channel: until the NUM_WIN-th window shows up, capped by the timeout.
    function automatic int exp_fills(int mode, int lat);
        int cnt = 0;
        int m;
        for (int p = 0; p < 400; p++) begin
            if (pulse_at(mode, p)) begin
                cnt++;
                if (cnt == NUM_WIN) begin
                    m = p + lat + 2;
                    if (m <= NUM_PIX) return 0;
                    if (m - NUM_PIX > FLUSH_MAX - 1) return FLUSH_MAX - 1;
                    return m - NUM_PIX;
                end
            end
        end
        return FLUSH_MAX - 1;
    endfunction

    logic [DATA_BITS-1:0] mem [0:3*NUM_PIX-1];
    int bmode = M_NORMAL;
    int blat  = 0;
    int bn    = 0;

    always @(posedge clk) begin
        if (fm_rd_en) fm_rd_data <= mem[fm_addr];
        else          fm_rd_data <= DATA_BITS'($urandom);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !buf_rst_n) begin
            bn = 0;
            buf_valid_out <= 1'b0;
        end else if (buf_valid_in) begin
            bn = bn + 1;
            buf_valid_out <= pulse_at(bmode, bn - 1 - blat);
        end else begin
            buf_valid_out <= 1'b0;
        end
    end

    int   exp_addr [$];
    win_t exp_win  [$];
    bit   mon_en = 1'b0;
    bit   prev_rd, prev_done, prev_brst;
    int   prev_addr, run, done_cnt, acc_cnt, rst_pulses, rst_low;
    int   fills [0:3];

    always @(negedge clk) begin
        win_t w;
        if (mon_en) begin
            if (fm_rd_en) begin
                if (exp_addr.size() == 0) check("rd_extra", int'(fm_addr), -1);
                else check("fm_addr", int'(fm_addr), exp_addr.pop_front());
                run++;
            end else if (run != 0) begin
                check("rd_run_len", run, NUM_PIX);
                run = 0;
            end
            if (prev_rd) begin
                check("vin_lag", int'(buf_valid_in), 1);
                check("vin_data", int'(buf_data_in), int'(mem[prev_addr]));
            end else if (buf_valid_in) begin
                check("fill_data", int'(buf_data_in), 0);
                fills[ch_idx]++;
            end
            if (acc_en) begin
                acc_cnt++;
                if (exp_win.size() == 0) begin
                    check("acc_extra", int'(win_idx), -1);
                end else begin
                    w = exp_win.pop_front();
                    check("win_idx", int'(win_idx), w.idx);
                    check("acc_first", int'(acc_first), w.first);
                    check("acc_last", int'(acc_last), w.last);
                    check("ch_idx", int'(ch_idx), w.ch);
                end
            end
            if (!buf_rst_n) begin
                rst_low++;
                if (prev_brst) rst_pulses++;
            end
            if (done) begin
                done_cnt++;
                check("busy_at_done", int'(busy), 1);
            end
            if (prev_done) check("busy_after_done", int'(busy), 0);
            prev_rd   = fm_rd_en;
            prev_addr = int'(fm_addr);
            prev_done = done;
            prev_brst = buf_rst_n;
        end
    end

    task automatic check_reset_vals(string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err_timeout), 0);
        check({tag, "_rd_en"}, int'(fm_rd_en), 0);
        check({tag, "_addr"}, int'(fm_addr), 0);
        check({tag, "_buf_rst_n"}, int'(buf_rst_n), 0);
        check({tag, "_vin"}, int'(buf_valid_in), 0);
        check({tag, "_din"}, int'(buf_data_in), 0);
        check({tag, "_acc_en"}, int'(acc_en), 0);
        check({tag, "_acc_first"}, int'(acc_first), 0);
        check({tag, "_acc_last"}, int'(acc_last), 0);
        check({tag, "_win_idx"}, int'(win_idx), 0);
        check({tag, "_ch_idx"}, int'(ch_idx), 0);
    endtask

    task automatic run_pass(input int nch, input int mode, input int lat, input bit ramp,
                            input bit poke, output int acc_out);
        int   n_eff;
        int   ef;
        int   cyc;
        bit   got;
        win_t w;
        n_eff = (nch == 0) ? 1 : nch;
        for (int a = 0; a < 3 * NUM_PIX; a++) mem[a] = ramp ? DATA_BITS'(a) : DATA_BITS'($urandom);
        exp_addr.delete();
        exp_win.delete();
        for (int a = 0; a < n_eff * NUM_PIX; a++) exp_addr.push_back(a);
        if (pulse_total(mode) >= NUM_WIN) begin
            for (int c = 0; c < n_eff; c++) begin
                for (int i = 0; i < NUM_WIN; i++) begin
                    w.idx = i; w.first = (c == 0); w.last = (c == n_eff - 1); w.ch = c;
                    exp_win.push_back(w);
                end
            end
        end
        ef    = exp_fills(mode, lat);
        bmode = mode;
        blat  = lat;
        prev_rd = 0; prev_done = 0; prev_brst = 1; prev_addr = 0;
        run = 0; done_cnt = 0; acc_cnt = 0; rst_pulses = 0; rst_low = 0;
        for (int c = 0; c < 4; c++) fills[c] = 0;
        mon_en = 1'b1;
        cfg_num_ch = CH_BITS'(nch);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_num_ch = CH_BITS'($urandom);
        check("busy_after_start", int'(busy), 1);
        check("err_clear_on_start", int'(err_timeout), 0);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 60) begin
                start = 1'b1;
                cfg_num_ch = CH_BITS'($urandom);
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        if (!got) begin
            check("done_seen", 0, 1);
            rst_n = 1'b0;
            #3 rst_n = 1'b1;
        end else begin
            if (poke) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            check("idle_after_fin", int'(busy), 0);
        end
        mon_en = 1'b0;
        check("addr_left", exp_addr.size(), 0);
        check("win_left", exp_win.size(), 0);
        check("done_count", done_cnt, 1);
        check("buf_rst_pulses", rst_pulses, n_eff);
        check("buf_rst_low_cycles", rst_low, n_eff);
        for (int c = 0; c < n_eff; c++) check("flush_fill_cycles", fills[c], ef);
        check("err_timeout_end", int'(err_timeout), (mode == M_NONE) ? 1 : 0);
        acc_out = acc_cnt;
    endtask

    task automatic reset_mid_stream();
        int cyc = 0;
        bit hit = 1'b0;
        for (int a = 0; a < 3 * NUM_PIX; a++) mem[a] = DATA_BITS'($urandom);
        bmode = M_NORMAL;
        blat  = 3;
        cfg_num_ch = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!hit && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (fm_rd_en && fm_addr == 10'd50) hit = 1'b1;
        end
        check("reached_addr50", int'(hit), 1);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        check("buf_rst_n_held", int'(buf_rst_n), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("buf_rst_n_rise", int'(buf_rst_n), 1);
        repeat (5) begin
            @(negedge clk);
            check("no_done_after_rst", int'(done), 0);
            check("idle_after_rst", int'(busy), 0);
        end
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_num_ch = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("buf_rst_n_after_reset", int'(buf_rst_n), 1);
        @(negedge clk);

        check("model_pulses_normal", pulse_total(M_NORMAL), 64);
        check("model_pulses_excess", pulse_total(M_EXCESS), 70);
        check("model_fill_normal_lat0", exp_fills(M_NORMAL, 0), 1);
        check("model_fill_none", exp_fills(M_NONE, 7), 63);
        check("model_fill_excess_lat10", exp_fills(M_EXCESS, 10), 5);

        run_pass(1, M_NORMAL, 0, 1'b1, 1'b0, acc);
        check("one_ch_windows", acc, 64);
        run_pass(3, M_NORMAL, int'($urandom_range(0, 30)), 1'b0, 1'b0, acc);
        check("three_ch_windows", acc, 192);
        run_pass(2, M_EXCESS, int'($urandom_range(0, 30)), 1'b0, 1'b0, acc);
        check("excess_windows", acc, 128);
        run_pass(2, M_NONE, 0, 1'b0, 1'b0, acc);
        check("none_windows", acc, 0);
        run_pass(1, M_NORMAL, int'($urandom_range(0, 30)), 1'b0, 1'b0, acc);
        check("after_timeout_windows", acc, 64);

        reset_mid_stream();
        run_pass(1, M_NORMAL, 2, 1'b1, 1'b0, acc);
        check("after_reset_windows", acc, 64);
        run_pass(0, M_NORMAL, int'($urandom_range(0, 30)), 1'b0, 1'b1, acc);
        check("zero_ch_windows", acc, 64);

        for (int k = 0; k < 4; k++) begin
            run_pass(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 30)), 1'b0, 1'($urandom_range(0, 1)), acc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
